// File: rtl/rtc_pkg.sv
// Shared constants, field widths and FSM state type for the RTC timekeeper.
package rtc_pkg;

    localparam int SEC_W   = 6;
    localparam int MIN_W   = 6;
    localparam int HR_W    = 5;

    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;
    localparam int HR_MAX  = 23;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        C_MIN = 2'd1,
        C_HR  = 2'd2,
        C_DAY = 2'd3
    } state_t;

endpackage

// File: rtl/rtc_wrap_counter.sv
// Loadable modulo-(MAX+1) counter; carry flags the increment that wraps to zero.
module rtc_wrap_counter
    import rtc_pkg::*;
#(
    parameter int W   = SEC_W,
    parameter int MAX = SEC_MAX
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         carry
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    assign carry = inc && (value == MAX_V);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (inc) begin
            value <= carry ? '0 : value + W'(1);
        end
    end

endmodule

// File: rtl/rtc_timekeeper.sv
// Time-of-day sequencer: ripples tick carries one field per clock, arbitrates
// host time-set requests against ticks and strobes an alarm on a time match.
module rtc_timekeeper
    import rtc_pkg::*;
#(
    parameter int DAY_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             set_req,
    input  logic [SEC_W-1:0] set_sec,
    input  logic [MIN_W-1:0] set_min,
    input  logic [HR_W-1:0]  set_hr,
    input  logic [DAY_W-1:0] set_day,
    output logic             set_ack,
    output logic             set_err,
    input  logic             alarm_en,
    input  logic [SEC_W-1:0] alarm_sec,
    input  logic [MIN_W-1:0] alarm_min,
    input  logic [HR_W-1:0]  alarm_hr,
    output logic [SEC_W-1:0] sec,
    output logic [MIN_W-1:0] min,
    output logic [HR_W-1:0]  hr,
    output logic [DAY_W-1:0] day,
    output logic             busy,
    output logic             alarm_pulse,
    output logic             overrun
);

    state_t state;
    logic   pending;
    logic   alarm_check;

    logic   eff_tick;
    logic   set_service;
    logic   set_valid;
    logic   set_load;
    logic   sec_inc, min_inc, hr_inc;
    logic   sec_carry, min_carry, hr_carry;
    logic   time_match;

    assign eff_tick    = tick || pending;
    assign busy        = (state != IDLE);
    // The cycle right after an ack belongs to the host dropping set_req, so it is never serviced.
    assign set_service = set_req && (state == IDLE) && !tick && !pending && !set_ack;
    assign set_valid   = (set_sec <= SEC_W'(SEC_MAX)) &&
                         (set_min <= MIN_W'(MIN_MAX)) &&
                         (set_hr  <= HR_W'(HR_MAX));
    assign set_load    = set_service && set_valid;

    assign sec_inc     = (state == IDLE) && eff_tick;
    assign min_inc     = (state == C_MIN);
    assign hr_inc      = (state == C_HR);
    assign time_match  = ({hr, min, sec} == {alarm_hr, alarm_min, alarm_sec});

    rtc_wrap_counter #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
        .clk      (clk),
        .rst      (rst),
        .load     (set_load),
        .load_val (set_sec),
        .inc      (sec_inc),
        .value    (sec),
        .carry    (sec_carry)
    );

    rtc_wrap_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
        .clk      (clk),
        .rst      (rst),
        .load     (set_load),
        .load_val (set_min),
        .inc      (min_inc),
        .value    (min),
        .carry    (min_carry)
    );

    rtc_wrap_counter #(.W(HR_W), .MAX(HR_MAX)) u_hr (
        .clk      (clk),
        .rst      (rst),
        .load     (set_load),
        .load_val (set_hr),
        .inc      (hr_inc),
        .value    (hr),
        .carry    (hr_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pending     <= 1'b0;
            overrun     <= 1'b0;
            alarm_check <= 1'b0;
            alarm_pulse <= 1'b0;
            set_ack     <= 1'b0;
            set_err     <= 1'b0;
            day         <= '0;
        end else begin
            set_ack     <= 1'b0;
            set_err     <= 1'b0;
            alarm_check <= 1'b0;
            alarm_pulse <= alarm_check && alarm_en && time_match;

            case (state)
                IDLE: begin
                    if (eff_tick) begin
                        // A fresh tick arriving while the pending one is consumed stays queued.
                        pending <= tick && pending;
                        if (sec_carry) state <= C_MIN;
                        else           alarm_check <= 1'b1;
                    end else if (set_service) begin
                        set_ack <= 1'b1;
                        set_err <= !set_valid;
                        if (set_valid) begin
                            day     <= set_day;
                            overrun <= 1'b0;
                        end
                    end
                end
                C_MIN: begin
                    if (min_carry) begin
                        state <= C_HR;
                    end else begin
                        state       <= IDLE;
                        alarm_check <= 1'b1;
                    end
                end
                C_HR: begin
                    if (hr_carry) begin
                        state <= C_DAY;
                    end else begin
                        state       <= IDLE;
                        alarm_check <= 1'b1;
                    end
                end
                default: begin
                    day         <= day + DAY_W'(1);
                    state       <= IDLE;
                    alarm_check <= 1'b1;
                end
            endcase

            if (state != IDLE && tick) begin
                if (pending) overrun <= 1'b1;
                else         pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Directed self-checking bench for rtc_timekeeper with hand-computed expectations.
module tb_rtc_timekeeper;

    localparam int DAY_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             tick;
    logic             set_req;
    logic [5:0]       set_sec;
    logic [5:0]       set_min;
    logic [4:0]       set_hr;
    logic [DAY_W-1:0] set_day;
    logic             set_ack;
    logic             set_err;
    logic             alarm_en;
    logic [5:0]       alarm_sec;
    logic [5:0]       alarm_min;
    logic [4:0]       alarm_hr;
    logic [5:0]       sec;
    logic [5:0]       min;
    logic [4:0]       hr;
    logic [DAY_W-1:0] day;
    logic             busy;
    logic             alarm_pulse;
    logic             overrun;

    int passed = 0;
    int total  = 0;

    rtc_timekeeper #(.DAY_W(DAY_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .set_req     (set_req),
        .set_sec     (set_sec),
        .set_min     (set_min),
        .set_hr      (set_hr),
        .set_day     (set_day),
        .set_ack     (set_ack),
        .set_err     (set_err),
        .alarm_en    (alarm_en),
        .alarm_sec   (alarm_sec),
        .alarm_min   (alarm_min),
        .alarm_hr    (alarm_hr),
        .sec         (sec),
        .min         (min),
        .hr          (hr),
        .day         (day),
        .busy        (busy),
        .alarm_pulse (alarm_pulse),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else             passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s, input int d);
        check({tag, "_hr"},  32'(hr),  32'(h));
        check({tag, "_min"}, 32'(min), 32'(m));
        check({tag, "_sec"}, 32'(sec), 32'(s));
        check({tag, "_day"}, 32'(day), 32'(d));
    endtask

    // Holds set_req until set_ack (bounded), checks set_err, then releases the request.
    task automatic set_time(input string tag, input int h, input int m, input int s, input int d,
                            input logic exp_err);
        bit acked = 1'b0;
        set_hr  = 5'(h);
        set_min = 6'(m);
        set_sec = 6'(s);
        set_day = DAY_W'(d);
        set_req = 1'b1;
        for (int i = 0; i < 20 && !acked; i++) begin
            step();
            acked = set_ack;
        end
        check({tag, "_ack"}, 32'(acked), 32'd1);
        check({tag, "_err"}, 32'(set_err), 32'(exp_err));
        set_req = 1'b0;
    endtask

    task automatic count_pulses(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            n += int'(alarm_pulse);
        end
    endtask

    initial begin
        int n;
        int busy_cycles;

        rst = 1'b1; tick = 1'b0; set_req = 1'b0;
        set_sec = '0; set_min = '0; set_hr = '0; set_day = '0;
        alarm_en = 1'b0; alarm_sec = '0; alarm_min = '0; alarm_hr = '0;
        step(); step();
        rst = 1'b0;
        step();

        check_time("reset", 0, 0, 0, 0);
        check("reset_busy",    32'(busy),        32'd0);
        check("reset_overrun", 32'(overrun),     32'd0);
        check("reset_alarm",   32'(alarm_pulse), 32'd0);
        check("reset_ack",     32'(set_ack),     32'd0);

        // Valid set, then a one-shot ack.
        set_time("set_ok", 12, 34, 56, 100, 1'b0);
        check_time("set_ok", 12, 34, 56, 100);
        step();
        check("ack_oneshot", 32'(set_ack), 32'd0);

        // Rejected set: sec out of range, time untouched.
        set_time("set_bad", 1, 1, 60, 7, 1'b1);
        check_time("set_bad", 12, 34, 56, 100);
        step();

        // Full rollover from 23:59:59 day 5.
        set_time("roll_set", 23, 59, 59, 5, 1'b0);
        tick = 1'b1; step(); tick = 1'b0;
        busy_cycles = int'(busy);
        check("roll_n_sec", 32'(sec), 32'd0);
        check("roll_n_min", 32'(min), 32'd59);
        step();
        busy_cycles += int'(busy);
        check("roll_n1_min", 32'(min), 32'd0);
        check("roll_n1_hr",  32'(hr),  32'd23);
        step();
        busy_cycles += int'(busy);
        check("roll_n2_hr",  32'(hr),  32'd0);
        check("roll_n2_day", 32'(day), 32'd5);
        step();
        check("roll_n3_day",  32'(day),  32'd6);
        check("roll_n3_busy", 32'(busy), 32'd0);
        check("roll_busy_cycles", 32'(busy_cycles), 32'd3);

        // Alarm at 00:00:10 reached by a tick.
        alarm_en = 1'b1; alarm_hr = 5'd0; alarm_min = 6'd0; alarm_sec = 6'd10;
        set_time("alm_set", 0, 0, 9, 0, 1'b0);
        step();
        tick = 1'b1; step(); tick = 1'b0;
        check("alm_sec", 32'(sec), 32'd10);
        check("alm_early", 32'(alarm_pulse), 32'd0);
        step();
        check("alm_pulse", 32'(alarm_pulse), 32'd1);
        count_pulses(4, n);
        check("alm_after", 32'(n), 32'd0);

        // Same tick with alarm disabled.
        alarm_en = 1'b0;
        set_time("alm_dis_set", 0, 0, 9, 0, 1'b0);
        step();
        tick = 1'b1; step(); tick = 1'b0;
        count_pulses(5, n);
        check("alm_disabled", 32'(n), 32'd0);

        // Set directly onto the alarm time.
        alarm_en = 1'b1;
        set_time("alm_direct_set", 0, 0, 10, 0, 1'b0);
        count_pulses(5, n);
        check("alm_direct", 32'(n), 32'd0);

        // Tick arriving in C_MIN is deferred to the first IDLE cycle.
        set_time("carry_set", 0, 0, 59, 0, 1'b0);
        step();
        tick = 1'b1; step();
        check("carry_n_sec", 32'(sec), 32'd0);
        step(); tick = 1'b0;
        check("carry_n1_min", 32'(min), 32'd1);
        check("carry_n1_sec", 32'(sec), 32'd0);
        step();
        check("carry_n2_sec",  32'(sec),     32'd1);
        check("carry_overrun", 32'(overrun), 32'd0);

        // Two ticks while busy: second one sets overrun, which sticks until a valid set.
        set_time("ovr_set", 0, 59, 59, 0, 1'b0);
        step();
        tick = 1'b1; step(); step(); step(); tick = 1'b0;
        check("ovr_flag", 32'(overrun), 32'd1);
        check_time("ovr_n2", 1, 0, 0, 0);
        step();
        check("ovr_pending_sec", 32'(sec), 32'd1);
        step(); step();
        check("ovr_sticky", 32'(overrun), 32'd1);
        set_time("ovr_clear_set", 1, 2, 3, 4, 1'b0);
        check("ovr_cleared", 32'(overrun), 32'd0);
        step();

        // Set and tick in the same IDLE cycle: tick first, ack one cycle later.
        set_hr = 5'd5; set_min = 6'd6; set_sec = 6'd7; set_day = DAY_W'(9);
        set_req = 1'b1; tick = 1'b1;
        step(); tick = 1'b0;
        check("coll_tick_sec", 32'(sec),     32'd4);
        check("coll_no_ack",   32'(set_ack), 32'd0);
        step();
        check("coll_ack", 32'(set_ack), 32'd1);
        check("coll_err", 32'(set_err), 32'd0);
        set_req = 1'b0;
        check_time("coll", 5, 6, 7, 9);
        step();

        // Reset in C_HR clears everything at once.
        set_time("rst_set", 23, 59, 59, 5, 1'b0);
        step();
        tick = 1'b1; step(); tick = 1'b0;
        step();
        check("rst_in_chr_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_time("rst_async", 0, 0, 0, 0);
        check("rst_async_busy", 32'(busy), 32'd0);
        step();
        rst = 1'b0;
        step(); step();
        check_time("rst_after", 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
